// File: rtl/sys_bus_pkg.sv
// Shared definitions for the system memory port: arbiter states,
// default bus widths and the rw encoding used by cache and memory.
package sys_bus_pkg;
   localparam int SYS_ADDR_W = 16;
   localparam int SYS_DATA_W = 8;

   localparam logic SYS_READ  = 1'b1;
   localparam logic SYS_WRITE = 1'b0;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_OWN0 = 2'd1,
      ARB_OWN1 = 2'd2
   } arb_state_t;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: a tie goes to the master that did not own last.
module rr_pick2 (
   input  logic       req0,
   input  logic       req1,
   input  logic       last,
   output logic [1:0] pick
);
   always_comb begin
      pick    = 2'b00;
      pick[0] = req0 & (~req1 | last);
      pick[1] = req1 & (~req0 | ~last);
   end
endmodule

// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter sharing the byte-wide memory port between two cache
// masters, with burst locking and a bounded hold when the other side waits.
module sys_bus_arbiter
   import sys_bus_pkg::*;
#(
   parameter int ADDR_W    = SYS_ADDR_W,
   parameter int DATA_W    = SYS_DATA_W,
   parameter int BURST_MAX = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m1_req,
   input  logic              m0_strobe,
   input  logic              m1_strobe,
   input  logic              m0_rw,
   input  logic              m1_rw,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [DATA_W-1:0] m0_data_out,
   input  logic [DATA_W-1:0] m1_data_out,
   output logic              m0_grant,
   output logic              m1_grant,
   output logic [DATA_W-1:0] m0_data_in,
   output logic [DATA_W-1:0] m1_data_in,
   output logic              sysstrobe,
   output logic              sysrw,
   output logic [ADDR_W-1:0] sysaddress,
   output logic [DATA_W-1:0] sysdata_out,
   input  logic [DATA_W-1:0] sysdata_in
);
   localparam logic [7:0] HOLD_SAT  = 8'(BURST_MAX);
   localparam logic [7:0] HOLD_LAST = 8'(BURST_MAX - 1);

   arb_state_t r_state, w_state_nxt;
   logic       r_last;
   logic [7:0] r_hold_cnt;
   logic [1:0] w_pick;
   logic       w_hold_done;

   rr_pick2 u_pick (
      .req0 (m0_req),
      .req1 (m1_req),
      .last (r_last),
      .pick (w_pick)
   );

   // >= rather than == so a master that saturated the counter while
   // uncontended is still preempted once the other side starts waiting.
   assign w_hold_done = (r_hold_cnt >= HOLD_LAST);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ARB_IDLE: begin
            if (w_pick[0])      w_state_nxt = ARB_OWN0;
            else if (w_pick[1]) w_state_nxt = ARB_OWN1;
         end
         ARB_OWN0: begin
            if (!m0_req)        w_state_nxt = m1_req ? ARB_OWN1 : ARB_IDLE;
            else if (m1_req && w_hold_done) w_state_nxt = ARB_OWN1;
         end
         ARB_OWN1: begin
            if (!m1_req)        w_state_nxt = m0_req ? ARB_OWN0 : ARB_IDLE;
            else if (m0_req && w_hold_done) w_state_nxt = ARB_OWN0;
         end
         default:               w_state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ARB_IDLE;
         r_last     <= 1'b1;
         r_hold_cnt <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_state_nxt != r_state && w_state_nxt != ARB_IDLE) begin
            r_hold_cnt <= 8'd0;
            r_last     <= (w_state_nxt == ARB_OWN1);
         end else if (r_state != ARB_IDLE && r_hold_cnt != HOLD_SAT) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
         end
      end
   end

   assign m0_grant = (r_state == ARB_OWN0);
   assign m1_grant = (r_state == ARB_OWN1);

   // Pure mux off registered state: no added latency on address/data paths.
   always_comb begin
      sysstrobe   = 1'b0;
      sysrw       = SYS_READ;
      sysaddress  = '0;
      sysdata_out = '0;
      m0_data_in  = '0;
      m1_data_in  = '0;
      if (m0_grant) begin
         sysstrobe   = m0_strobe;
         sysrw       = m0_rw;
         sysaddress  = m0_address;
         sysdata_out = m0_data_out;
         m0_data_in  = sysdata_in;
      end else if (m1_grant) begin
         sysstrobe   = m1_strobe;
         sysrw       = m1_rw;
         sysaddress  = m1_address;
         sysdata_out = m1_data_out;
         m1_data_in  = sysdata_in;
      end
   end
endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Directed bench for sys_bus_arbiter with a small byte memory on the sys port.
module tb_sys_bus_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req, m1_req, m0_strobe, m1_strobe, m0_rw, m1_rw;
   logic [15:0] m0_address, m1_address;
   logic [7:0]  m0_data_out, m1_data_out;
   logic        m0_grant, m1_grant;
   logic [7:0]  m0_data_in, m1_data_in;
   logic        sysstrobe, sysrw;
   logic [15:0] sysaddress;
   logic [7:0]  sysdata_out, sysdata_in;

   logic [7:0]  mem [0:255];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cnt;

   always #5 clk = ~clk;

   sys_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .BURST_MAX(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m1_req(m1_req),
      .m0_strobe(m0_strobe), .m1_strobe(m1_strobe),
      .m0_rw(m0_rw), .m1_rw(m1_rw),
      .m0_address(m0_address), .m1_address(m1_address),
      .m0_data_out(m0_data_out), .m1_data_out(m1_data_out),
      .m0_grant(m0_grant), .m1_grant(m1_grant),
      .m0_data_in(m0_data_in), .m1_data_in(m1_data_in),
      .sysstrobe(sysstrobe), .sysrw(sysrw), .sysaddress(sysaddress),
      .sysdata_out(sysdata_out), .sysdata_in(sysdata_in)
   );

   assign sysdata_in = mem[sysaddress[7:0]];
   always @(posedge clk)
      if (sysstrobe && !sysrw) mem[sysaddress[7:0]] <= sysdata_out;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_req = 0; m1_req = 0; m0_strobe = 0; m1_strobe = 0;
      m0_rw = 1; m1_rw = 1; m0_address = 0; m1_address = 0;
      m0_data_out = 0; m1_data_out = 0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h10] = 8'h5A;
      mem[8'h31] = 8'h3C;
      idle_inputs();
      rst_n = 0;
      tick(); tick();
      rst_n = 1;
      #1;
      chk("rst_g0", m0_grant, 0);
      chk("rst_g1", m1_grant, 0);
      chk("rst_strobe", sysstrobe, 0);
      chk("rst_rw", sysrw, 1);
      chk("rst_addr", sysaddress, 0);

      // single master read
      m0_req = 1; m0_strobe = 1; m0_rw = 1; m0_address = 16'h0010;
      #1;
      chk("rd_pre_grant", m0_grant, 0);
      chk("rd_pre_strobe", sysstrobe, 0);
      tick();
      chk("rd_grant", m0_grant, 1);
      chk("rd_strobe", sysstrobe, 1);
      chk("rd_addr", sysaddress, 16'h0010);
      chk("rd_data0", m0_data_in, 8'h5A);
      chk("rd_data1", m1_data_in, 0);
      idle_inputs();
      tick();
      chk("rd_release", m0_grant, 0);

      // tie out of reset, then handoff without idle bubble
      rst_n = 0; tick(); rst_n = 1;
      m0_req = 1; m1_req = 1;
      tick();
      chk("tie_g0", m0_grant, 1);
      chk("tie_g1", m1_grant, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("tie_hold", m0_grant, 1);
      end
      m0_req = 0;
      tick();
      chk("handoff_g0", m0_grant, 0);
      chk("handoff_g1", m1_grant, 1);
      m1_req = 0;
      tick();
      chk("handoff_idle", m1_grant, 0);

      // contended hold limit
      m0_req = 1; m1_req = 1;
      tick();
      cnt = 0;
      while (m0_grant && cnt < 20) begin
         cnt++;
         tick();
      end
      chk("burst_len", cnt, 8);
      chk("burst_g1", m1_grant, 1);
      m1_req = 0;
      tick();
      chk("regrant_g0", m0_grant, 1);

      // non-owner strobe must not reach memory
      m1_strobe = 1; m1_rw = 0; m1_address = 16'h0031; m1_data_out = 8'hA5;
      m0_strobe = 0; m0_rw = 1; m0_address = 16'h0040;
      #1;
      chk("iso_strobe", sysstrobe, 0);
      chk("iso_addr", sysaddress, 16'h0040);
      chk("iso_rw", sysrw, 1);
      tick();
      m0_strobe = 1; m0_address = 16'h0031;
      #1;
      chk("iso_strobe_own", sysstrobe, 1);
      chk("iso_mem", m0_data_in, 8'h3C);
      chk("iso_data1", m1_data_in, 0);
      tick();
      idle_inputs();
      tick();

      // reset in the middle of an m1 write burst
      m1_req = 1;
      tick();
      chk("wb_g1", m1_grant, 1);
      m1_strobe = 1; m1_rw = 0; m1_address = 16'h0050; m1_data_out = 8'h77;
      #1;
      chk("wb_strobe", sysstrobe, 1);
      chk("wb_rw", sysrw, 0);
      tick();
      rst_n = 0;
      tick();
      chk("mrst_g0", m0_grant, 0);
      chk("mrst_g1", m1_grant, 0);
      chk("mrst_strobe", sysstrobe, 0);
      chk("mrst_rw", sysrw, 1);
      chk("wb_mem", mem[8'h50], 8'h77);
      rst_n = 1; m0_req = 1;
      tick();
      chk("mrst_tie_g0", m0_grant, 1);
      chk("mrst_tie_g1", m1_grant, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/sys_bus_arbiter.md
# sys_bus_arbiter

Two-master arbiter for the byte-wide system memory port. Shares one `memory` instance between two cache controllers (instruction and data side), each of which drives the same strobe/rw/address/data signal set the cache already drives toward memory. Round-robin ownership with burst locking and a hold timeout, so neither side starves during 4-byte word fills or write-backs.

## Interface
Parameters:
- `ADDR_W`, 16, system address width
- `DATA_W`, 8, system data width
- `BURST_MAX`, 8, maximum cycles one master keeps the bus while the other is waiting; legal range 1–255

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `m0_req`, `m1_req`  in  1  bus request, held for the whole burst
- `m0_strobe`, `m1_strobe`  in  1  per-access strobe from the master
- `m0_rw`, `m1_rw`  in  1  1 = read, 0 = write
- `m0_address`, `m1_address`  in  ADDR_W  access address
- `m0_data_out`, `m1_data_out`  in  DATA_W  write data from the master
- `m0_grant`, `m1_grant`  out  1  master owns the bus (registered)
- `m0_data_in`, `m1_data_in`  out  DATA_W  read data returned to the master
- `sysstrobe`  out  1  to memory
- `sysrw`  out  1  to memory
- `sysaddress`  out  ADDR_W  to memory
- `sysdata_out`  out  DATA_W  write data to memory
- `sysdata_in`  in  DATA_W  read data from memory

## Operation
- States: IDLE, OWN0, OWN1. `last` (1 bit) records the most recent owner. `hold_cnt` counts cycles in the current ownership.
- IDLE: neither request → stay. One request → grant that master. Both → grant `!last`.
- OWNx, `mx_req` low → release. If the other master is requesting, go directly to OWNy with no idle bubble. Otherwise go to IDLE.
- OWNx, `mx_req` high, other not requesting → stay. `hold_cnt` saturates at BURST_MAX.
- OWNx, `mx_req` high, other requesting, `hold_cnt == BURST_MAX-1` → preempt to OWNy.
  - The preempted master keeps `req` high and regains the bus by round-robin.
  - The master must re-issue any access whose strobe fell in a cycle without grant.
- On entry to any OWN state: `hold_cnt` ← 0 and `last` ← new owner.
- Output mux is combinational from the registered state.
  - `sysstrobe = mx_strobe & mx_grant` of the owner. A strobe from a master without grant never reaches memory.
  - `sysrw`, `sysaddress`, `sysdata_out` come from the owner.
  - `mx_data_in = sysdata_in` for the owner, 0 for the non-owner.
- IDLE outputs: `sysstrobe`=0, `sysrw`=1, `sysaddress`=0, `sysdata_out`=0.
- Reset values: state IDLE, both grants 0, `last`=1 (m0 wins the first tie), `hold_cnt`=0, all sys outputs at their IDLE values.

## Timing
- Grant latency: a request sampled at edge n gives grant high after edge n, which is 1 cycle.
- Release: `req` low sampled at edge n → grant low after edge n. The waiting master's grant rises after the same edge, so the bus is never double-owned.
- Contended hold: grant stays high for exactly BURST_MAX cycles.
- Memory-side latency is unchanged. The arbiter adds no pipeline stage on the address or data paths.
- Reset mid-burst: `rst_n` low sampled at edge n → both grants and `sysstrobe` are 0 after edge n, regardless of state.
- Simultaneous release by the owner and a new request from the other master: direct handoff, as in the release rule.

## Structure
- Package `sys_bus_pkg` holds:
  - the state enum (IDLE/OWN0/OWN1)
  - `ADDR_W`, `DATA_W` defaults
  - the `SYS_READ`=1 / `SYS_WRITE`=0 constants shared with `cache` and `memory`
- One sub-module, `rr_pick2`: combinational two-way round-robin selector with inputs (req0, req1, last) and one-hot pick output. It is reused by the top-level FSM.
- The `hold_cnt` counter and the output mux stay in the top level.

## Test plan
- m0 requests alone, reads byte at 0x0010: `m0_grant` high 1 cycle after `req`; `sysaddress`=0x0010; `m0_data_in` = memory byte; `m1_data_in`=0.
- Both masters request in the same cycle out of reset → m0 granted first. m0 drops `req` after 4 cycles → m1 granted the next cycle with no IDLE cycle between.
- m0 holds `req` continuously, m1 requests, BURST_MAX=8 → m0 grant lasts exactly 8 cycles, then m1 is granted. m0 is regranted after m1 releases.
- m1 asserts strobe with rw=0, address 0x0031, data 0xA5 while m0 owns the bus → `sysstrobe` follows only m0, and memory 0x0031 is unchanged.
- `rst_n` pulled low for 1 cycle during an m1 write burst → both grants and `sysstrobe` are 0 the next cycle. `sysrw`=1. The next tie goes to m0.
